vga_image_scanout: RTL and testbench
====================================

Name: vga_image_scanout

Overview:
- Display-side consumer of the I/O memory's GPU read port.
- Generates 640x480@60 Hz VGA timing on the pixel clock and walks the image region one pixel at a time through a single shared read address.
- Turns the two returned 8-bit grayscale streams (encrypted image, decrypted image) into two side-by-side windows on screen, with black everywhere else.
- Drives the board VGA DAC directly.

Parameters:
- H_VISIBLE, 640: active pixels per line
- H_FRONT, 16: horizontal front porch
- H_SYNC, 96: hsync pulse width
- H_BACK, 48: horizontal back porch
- V_VISIBLE, 480: active lines
- V_FRONT, 10: vertical front porch
- V_SYNC, 2: vsync pulse width
- V_BACK, 33: vertical back porch
- IMG_W, 256: image width in pixels
- IMG_H, 256: image height in pixels
- X0_ENC, 32: left column of the encrypted-image window
- X0_DEC, 352: left column of the decrypted-image window
- Y0, 112: top row of both windows

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-high
- show_decrypted  in  1  enables the decrypted window
- encrypted_gpu  in  8  encrypted pixel byte; valid one clk after gpu_address
- decrypted_gpu  in  8  decrypted pixel byte; valid one clk after gpu_address
- gpu_address  out  32  shared byte address for both image reads
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_blank_n  out  1  high in the visible area
- vga_r  out  8  red channel
- vga_g  out  8  green channel
- vga_b  out  8  blue channel
- frame_start  out  1  one-clk pulse aligned with the first visible pixel

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on the port named reset. There are no other clocks.
- Counters:
  - h counts 0..799 and wraps to 0.
  - v increments when h==799 and wraps 524 to 0.
  - Line total is H_VISIBLE+H_FRONT+H_SYNC+H_BACK; frame total is V_VISIBLE+V_FRONT+V_SYNC+V_BACK.
- Stage 0 (counters at value h,v):
  - in_enc = X0_ENC<=h<X0_ENC+IMG_W and Y0<=v<Y0+IMG_H.
  - in_dec uses the same test with X0_DEC.
  - Windows must not overlap; this is a parameter legality check.
- Stage 1 (next edge):
  - gpu_address <= (v-Y0)*IMG_W + (h-X0), using the X0 of whichever window is active; otherwise it holds its last value.
  - The product is computed by an incremental row base: +IMG_W at the end of each window line, cleared when v wraps. No multiplier.
  - Address range is 0..IMG_W*IMG_H-1.
  - Raw sync, visible and window flags are delayed one stage.
- Stage 2 (next edge, memory data valid):
  - in_enc: r=g=b=encrypted_gpu.
  - in_dec and show_frame: r=g=b=decrypted_gpu.
  - Otherwise r=g=b=0, including in_dec with show_frame=0.
  - hsync = !(656<=h<752) and vsync = !(490<=v<492), both delayed two stages.
  - blank_n = (h<640 && v<480), delayed two stages.
- Latency: every output lags the counters by exactly 2 clk. All outputs stay mutually aligned.
- show_frame:
  - Latched from show_decrypted only on the edge where the counters become (0,0).
  - A mid-frame change takes effect from the next frame, so there is no tearing.
- frame_start is 1 for exactly the single clk in which the stage-2 outputs show pixel (0,0).
- Reset values:
  - counters 0, gpu_address 0, show_frame 0
  - vga_hsync=1, vga_vsync=1, vga_blank_n=0, rgb=0, frame_start=0
  - all pipeline flags cleared
- Reset mid-frame: all of the above applies on the next edge. The first frame_start occurs 2 clk after the counters restart at (0,0), i.e. 2 clk after reset deasserts.
- Wrap: at h=799, v=524 the next counter value is (0,0), with no idle cycle.

Decomposition:
- Package vga_pkg:
  - timing constants: H_TOTAL=800, V_TOTAL=525, sync start/end columns and rows
  - typedef pixel_t (logic[7:0])
  - typedef coord_t (logic[9:0])
- Sub-module vga_timing_counter: h/v counters, raw sync, visible flag, frame-wrap strobe. The parent handles windowing, addressing and the pixel pipeline.

Test Plan:
- Reset held 3 clk, then released -> vga_hsync=1, vga_blank_n=0, rgb=0, gpu_address=0 during reset; frame_start=1 exactly 2 clk after release.
- Free run for one line -> vga_hsync low for 96 clk starting 656 clk after line start; vga_blank_n high for 640 clk; line period 800 clk; frame_start period 420000 clk.
- Memory model returns address[7:0], or 255-address[7:0] for decrypted, show_decrypted=1:
  - pixel (32,112) -> gpu_address 0, vga_r=0x00
  - pixel (287,367) -> address 65535
  - pixel (352,113) -> address 256, vga_r=0xFF
  - pixel (300,50) -> rgb 0
- show_decrypted 0->1 at line 200 -> decrypted window stays black for the rest of the frame and shows data from line 112 of the next frame.
- Reset asserted at (400,300) -> next edge shows reset values; counters restart at 0; address sequence matches a fresh frame.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and the default 640x480@60 Hz timing geometry used by the VGA
// image scanout block and its timing counter.
//   pixel_t : one 8-bit grayscale sample
//   coord_t : one 10-bit screen coordinate (covers 0..799 and 0..524)
//   in_span : half-open range test lo <= x < hi on screen coordinates
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef logic [7:0] pixel_t;
    typedef logic [9:0] coord_t;

    // Default 640x480@60 Hz geometry.
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;

    function automatic logic in_span(input coord_t x, input coord_t lo, input coord_t hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// -----------------------------------------------------------------------------
// vga_timing_counter
// Free-running horizontal/vertical pixel counters with the raw (undelayed)
// timing flags derived from them.
//   i_clk          : pixel clock
//   i_reset        : synchronous, active-high; counters return to (0,0)
//   o_h, o_v       : current column / line
//   o_hsync_raw    : active-low horizontal sync for the current column
//   o_vsync_raw    : active-low vertical sync for the current line
//   o_visible      : current (h,v) lies in the active picture
//   o_frame_wrap   : counters are at the last pixel of the frame, so the next
//                    edge brings them back to (0,0)
// -----------------------------------------------------------------------------
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic   i_clk,
    input  logic   i_reset,
    output coord_t o_h,
    output coord_t o_v,
    output logic   o_hsync_raw,
    output logic   o_vsync_raw,
    output logic   o_visible,
    output logic   o_frame_wrap
);

    localparam coord_t C_H_LAST     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t C_V_LAST     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t C_H_VIS      = coord_t'(H_VISIBLE);
    localparam coord_t C_V_VIS      = coord_t'(V_VISIBLE);
    localparam coord_t C_HS_START   = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t C_HS_END     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t C_VS_START   = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t C_VS_END     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t r_h;
    coord_t r_v;
    logic   w_h_last;
    logic   w_v_last;

    assign w_h_last = (r_h == C_H_LAST);
    assign w_v_last = (r_v == C_V_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    assign o_h          = r_h;
    assign o_v          = r_v;
    assign o_hsync_raw  = !in_span(r_h, C_HS_START, C_HS_END);
    assign o_vsync_raw  = !in_span(r_v, C_VS_START, C_VS_END);
    assign o_visible    = (r_h < C_H_VIS) && (r_v < C_V_VIS);
    assign o_frame_wrap = w_h_last && w_v_last;

endmodule

// File: rtl/vga_image_scanout.sv
// -----------------------------------------------------------------------------
// vga_image_scanout
// Scans out two side-by-side grayscale image windows (encrypted on the left,
// decrypted on the right) on a VGA raster, fetching pixels through one shared
// GPU read address. All outputs lag the raster counters by two clocks.
//   clk, reset       : pixel clock, synchronous active-high reset
//   show_decrypted   : enables the decrypted window (sampled once per frame)
//   encrypted_gpu    : encrypted byte for gpu_address, valid one clk later
//   decrypted_gpu    : decrypted byte for gpu_address, valid one clk later
//   gpu_address      : shared image byte address, 0..IMG_W*IMG_H-1
//   vga_hsync/vsync  : active-low syncs
//   vga_blank_n      : high in the active picture
//   vga_r/g/b        : grayscale replicated on all three channels
//   frame_start      : one-clk pulse while pixel (0,0) is on the outputs
// -----------------------------------------------------------------------------
module vga_image_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int X0_ENC    = 32,
    parameter int X0_DEC    = 352,
    parameter int Y0        = 112
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        show_decrypted,
    input  pixel_t      encrypted_gpu,
    input  pixel_t      decrypted_gpu,
    output logic [31:0] gpu_address,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output pixel_t      vga_r,
    output pixel_t      vga_g,
    output pixel_t      vga_b,
    output logic        frame_start
);

    if ((X0_ENC < X0_DEC + IMG_W) && (X0_DEC < X0_ENC + IMG_W)) begin : g_overlap
        $error("vga_image_scanout: encrypted and decrypted windows overlap");
    end

    localparam coord_t C_X0_ENC  = coord_t'(X0_ENC);
    localparam coord_t C_XE_ENC  = coord_t'(X0_ENC + IMG_W);
    localparam coord_t C_X0_DEC  = coord_t'(X0_DEC);
    localparam coord_t C_XE_DEC  = coord_t'(X0_DEC + IMG_W);
    localparam coord_t C_Y0      = coord_t'(Y0);
    localparam coord_t C_YE      = coord_t'(Y0 + IMG_H);
    // Last column of whichever window sits further right: the row base may
    // only advance once both windows have finished the current image line.
    localparam coord_t C_X_LAST  = coord_t'(((X0_ENC > X0_DEC) ? X0_ENC : X0_DEC) + IMG_W - 1);

    coord_t w_h;
    coord_t w_v;
    logic   w_hsync_raw;
    logic   w_vsync_raw;
    logic   w_visible;
    logic   w_frame_wrap;

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .i_clk        (clk),
        .i_reset      (reset),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_hsync_raw  (w_hsync_raw),
        .o_vsync_raw  (w_vsync_raw),
        .o_visible    (w_visible),
        .o_frame_wrap (w_frame_wrap)
    );

    // ---- stage 0: window decode on the live counters ----
    logic   w_row_in;
    logic   w_in_enc;
    logic   w_in_dec;
    logic   w_first;
    coord_t w_col;

    assign w_row_in = in_span(w_v, C_Y0, C_YE);
    assign w_in_enc = w_row_in && in_span(w_h, C_X0_ENC, C_XE_ENC);
    assign w_in_dec = w_row_in && in_span(w_h, C_X0_DEC, C_XE_DEC);
    assign w_first  = (w_h == '0) && (w_v == '0);
    assign w_col    = w_in_enc ? (w_h - C_X0_ENC) : (w_h - C_X0_DEC);

    // ---- stage 1: address issue, flags delayed one clock ----
    logic [31:0] r_row_base;
    logic [31:0] r_addr_p1;
    logic        r_hsync_p1;
    logic        r_vsync_p1;
    logic        r_visible_p1;
    logic        r_in_enc_p1;
    logic        r_in_dec_p1;
    logic        r_first_p1;
    logic        r_show_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_base   <= '0;
            r_addr_p1    <= '0;
            r_hsync_p1   <= 1'b1;
            r_vsync_p1   <= 1'b1;
            r_visible_p1 <= 1'b0;
            r_in_enc_p1  <= 1'b0;
            r_in_dec_p1  <= 1'b0;
            r_first_p1   <= 1'b0;
            r_show_frame <= 1'b0;
        end else begin
            // Address holds outside the windows so the memory sees no churn.
            if (w_in_enc || w_in_dec) begin
                r_addr_p1 <= r_row_base + 32'(w_col);
            end
            if (w_frame_wrap) begin
                r_row_base <= '0;
            end else if (w_row_in && (w_h == C_X_LAST)) begin
                r_row_base <= r_row_base + 32'(IMG_W);
            end
            // Sampled only at the frame boundary so a toggle never tears.
            if (w_frame_wrap) begin
                r_show_frame <= show_decrypted;
            end
            r_hsync_p1   <= w_hsync_raw;
            r_vsync_p1   <= w_vsync_raw;
            r_visible_p1 <= w_visible;
            r_in_enc_p1  <= w_in_enc;
            r_in_dec_p1  <= w_in_dec;
            r_first_p1   <= w_first;
        end
    end

    // ---- stage 2: memory data valid, pixel select ----
    pixel_t r_pix_p2;
    logic   r_hsync_p2;
    logic   r_vsync_p2;
    logic   r_blank_n_p2;
    logic   r_frame_start_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_p2         <= '0;
            r_hsync_p2       <= 1'b1;
            r_vsync_p2       <= 1'b1;
            r_blank_n_p2     <= 1'b0;
            r_frame_start_p2 <= 1'b0;
        end else begin
            if (r_in_enc_p1) begin
                r_pix_p2 <= encrypted_gpu;
            end else if (r_in_dec_p1 && r_show_frame) begin
                r_pix_p2 <= decrypted_gpu;
            end else begin
                r_pix_p2 <= '0;
            end
            r_hsync_p2       <= r_hsync_p1;
            r_vsync_p2       <= r_vsync_p1;
            r_blank_n_p2     <= r_visible_p1;
            r_frame_start_p2 <= r_first_p1;
        end
    end

    assign gpu_address = r_addr_p1;
    assign vga_hsync   = r_hsync_p2;
    assign vga_vsync   = r_vsync_p2;
    assign vga_blank_n = r_blank_n_p2;
    assign vga_r       = r_pix_p2;
    assign vga_g       = r_pix_p2;
    assign vga_b       = r_pix_p2;
    assign frame_start = r_frame_start_p2;

endmodule

// File: tb/tb_vga_image_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_image_scanout
// Drives the scanout block with a reduced raster geometry (so several whole
// frames fit in a short run) and compares every output on every clock with a
// position-based reference: output time index n shows raster position n-2,
// gpu_address shows the last window pixel at or before position n-1.
// Memory returns address[7:0] (encrypted) and 255-address[7:0] (decrypted).
// -----------------------------------------------------------------------------
module tb_vga_image_scanout;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 3;
    localparam int IW = 16, IH = 16, XE = 4, XD = 36, Y0 = 12;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        show_decrypted;
    logic [7:0]  encrypted_gpu;
    logic [7:0]  decrypted_gpu;
    logic [31:0] gpu_address;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;

    always #20 clk = ~clk;

    // Asynchronous-read memory: data follows the registered address.
    assign encrypted_gpu = gpu_address[7:0];
    assign decrypted_gpu = 8'd255 - gpu_address[7:0];

    vga_image_scanout #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .IMG_W (IW), .IMG_H (IH), .X0_ENC (XE), .X0_DEC (XD), .Y0 (Y0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .show_decrypted (show_decrypted),
        .encrypted_gpu  (encrypted_gpu),
        .decrypted_gpu  (decrypted_gpu),
        .gpu_address    (gpu_address),
        .vga_hsync      (vga_hsync),
        .vga_vsync      (vga_vsync),
        .vga_blank_n    (vga_blank_n),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .frame_start    (frame_start)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    longint idx    = 0;      // clocks since the counters were last at (0,0) by reset
    longint exp_addr = 0;
    bit    show_of_frame [longint];
    bit    s_show = 1'b0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle index %0d)", tag, act, exp, idx);
        end
    endtask

    function automatic bit in_win(input longint q, input int x0);
        int h = int'(q % HT);
        int v = int'((q / HT) % VT);
        return (h >= x0) && (h < x0 + IW) && (v >= Y0) && (v < Y0 + IH);
    endfunction

    function automatic longint addr_of(input longint q, input int x0);
        int h = int'(q % HT);
        int v = int'((q / HT) % VT);
        return longint'((v - Y0) * IW + (h - x0));
    endfunction

    task automatic step(input bit rst, input bit show);
        longint q;
        int     h, v;
        longint a;
        bit     e_hs, e_vs, e_bl, e_fs;
        int     e_pix;
        reset          = rst;
        show_decrypted = show;
        @(posedge clk);
        if (rst) begin
            idx      = 0;
            exp_addr = 0;
            show_of_frame.delete();
            show_of_frame[0] = 1'b0;
        end else begin
            idx++;
            if (idx % FT == 0) show_of_frame[idx / FT] = show;
            if (in_win(idx - 1, XE))      exp_addr = addr_of(idx - 1, XE);
            else if (in_win(idx - 1, XD)) exp_addr = addr_of(idx - 1, XD);
        end
        #1;
        if (rst || idx < 2) begin
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_pix = 0; e_fs = 1'b0;
        end else begin
            q = idx - 2;
            h = int'(q % HT);
            v = int'((q / HT) % VT);
            e_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
            e_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
            e_bl  = (h < HV) && (v < VV);
            e_fs  = (q % FT == 0);
            e_pix = 0;
            if (in_win(q, XE)) begin
                a     = addr_of(q, XE);
                e_pix = int'(a % 256);
            end else if (in_win(q, XD) && show_of_frame[q / FT]) begin
                a     = addr_of(q, XD);
                e_pix = 255 - int'(a % 256);
            end
        end
        check_eq("gpu_address", gpu_address, exp_addr);
        check_eq("vga_r", vga_r, e_pix);
        check_eq("vga_g", vga_g, e_pix);
        check_eq("vga_b", vga_b, e_pix);
        check_eq("vga_hsync", vga_hsync, e_hs);
        check_eq("vga_vsync", vga_vsync, e_vs);
        check_eq("vga_blank_n", vga_blank_n, e_bl);
        check_eq("frame_start", frame_start, e_fs);
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 1499) == 0) s_show = ~s_show;
            step(1'b0, s_show);
        end
    endtask

    initial begin
        show_of_frame[0] = 1'b0;
        reset          = 1'b1;
        show_decrypted = 1'b1;

        // Reset held 3 clocks with show requested: first frame still hides
        // the decrypted window because the latch clears on reset.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        // Frame 0 and frame 1 up to image line 8 with show low, then raise
        // it mid-window: frame 1 stays dark, frame 2 shows decrypted data.
        while (idx < FT + (Y0 + 8) * HT) step(1'b0, 1'b0);
        while (idx < 3 * FT) step(1'b0, 1'b1);
        s_show = 1'b1;

        run_random(2 * FT);

        // Reset asserted with the counters at column 40, line 30.
        while (idx % FT != longint'(30 * HT + 40)) step(1'b0, s_show);
        step(1'b1, s_show);
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) step(1'b1, s_show);
        run_random(2 * FT + 10);

        // Reset at a random point of the frame.
        run_random(int'($urandom_range(100, FT)));
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1, s_show);
        run_random(FT + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
